// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR channel scheduler.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } sched_state_t;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_NUM_CH  = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_if.sv
// Engine-side handshake plus tagged result stream of the scheduler.
interface fir_channel_scheduler_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH_W  = 2
);
    logic signed [WIDTH-1:0] eng_audio_out;
    logic [CH_W-1:0]         eng_ch_out;
    logic                    eng_valid_out;
    logic signed [WIDTH-1:0] eng_audio_in;
    logic                    eng_ready_in;
    logic signed [WIDTH-1:0] result_out;
    logic [CH_W-1:0]         result_ch_out;
    logic                    result_valid_out;

    // Scheduler side.
    modport master (
        output eng_audio_out, eng_ch_out, eng_valid_out,
        output result_out, result_ch_out, result_valid_out,
        input  eng_audio_in, eng_ready_in
    );

    // Engine and result consumer side.
    modport slave (
        input  eng_audio_out, eng_ch_out, eng_valid_out,
        input  result_out, result_ch_out, result_valid_out,
        output eng_audio_in, eng_ready_in
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_any
);

    logic [CH_W-1:0] idx;

    // Scan NUM_CH positions starting just after the previous winner.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((32'(last_grant) + i) % NUM_CH);
            if (!grant_any && pending[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexes one FIR engine across NUM_CH channels, round-robin.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned NUM_CH  = DEFAULT_NUM_CH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_CH*WIDTH-1:0] ch_audio_in,
    input  logic [NUM_CH-1:0]       ch_valid_in,
    input  logic                    clr_err_in,
    fir_channel_scheduler_if.master bus,
    output logic                    busy_out,
    output logic [NUM_CH-1:0]       overrun_out,
    output logic                    timeout_out
);

    localparam int unsigned CH_W  = ch_w(NUM_CH);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    sched_state_t            state, state_nxt;
    logic [NUM_CH-1:0]       pending, pending_nxt, ov_evt;
    logic signed [WIDTH-1:0] sample [NUM_CH];
    logic [CH_W-1:0]         last_grant, grant, grant_idx;
    logic                    grant_any;
    logic [TMR_W-1:0]        timer;
    logic                    load_grant, do_issue, capture, expire;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .pending    (pending),
        .last_grant (last_grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        do_issue   = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt  = ISSUE;
                    load_grant = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                do_issue  = 1'b1;
            end
            WAIT: begin
                if (bus.eng_ready_in) begin
                    state_nxt = EMIT;
                    capture   = 1'b1;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    expire    = 1'b1;
                end
            end
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pending bank update; a re-request during the granted channel's ISSUE is not an overrun.
    always_comb begin
        pending_nxt = pending;
        ov_evt      = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (do_issue && grant == CH_W'(c)) begin
                pending_nxt[c] = ch_valid_in[c];
            end else if (ch_valid_in[c]) begin
                pending_nxt[c] = 1'b1;
                ov_evt[c]      = pending[c];
            end
        end
    end

    // Datapath, timer, registered outputs and sticky error flags.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pending              <= '0;
            last_grant           <= CH_W'(NUM_CH - 1);
            grant                <= '0;
            timer                <= '0;
            bus.eng_audio_out    <= '0;
            bus.eng_ch_out       <= '0;
            bus.eng_valid_out    <= 1'b0;
            bus.result_out       <= '0;
            bus.result_ch_out    <= '0;
            bus.result_valid_out <= 1'b0;
            busy_out             <= 1'b0;
            overrun_out          <= '0;
            timeout_out          <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) sample[c] <= '0;
        end else begin
            pending <= pending_nxt;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (ch_valid_in[c]) sample[c] <= ch_audio_in[c*WIDTH +: WIDTH];
            end
            if (load_grant) begin
                grant             <= grant_idx;
                bus.eng_ch_out    <= grant_idx;
                bus.eng_audio_out <= sample[grant_idx];
            end
            bus.eng_valid_out <= load_grant;
            if (do_issue) begin
                last_grant <= grant;
                timer      <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TMR_W'(1);
            end
            if (capture) begin
                bus.result_out    <= bus.eng_audio_in;
                bus.result_ch_out <= grant;
            end
            bus.result_valid_out <= capture;
            busy_out             <= (state_nxt != IDLE);
            overrun_out          <= (overrun_out & ~{NUM_CH{clr_err_in}}) | ov_evt;
            timeout_out          <= (timeout_out & ~clr_err_in) | expire;
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler (WIDTH=8, NUM_CH=4, TIMEOUT=64).
module tb_fir_channel_scheduler;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned TIMEOUT = 64;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [NUM_CH*WIDTH-1:0] ch_audio_in;
    logic [NUM_CH-1:0]       ch_valid_in;
    logic                    clr_err_in;
    logic                    busy_out;
    logic [NUM_CH-1:0]       overrun_out;
    logic                    timeout_out;

    int total = 0;
    int bad   = 0;

    fir_channel_scheduler_if #(.WIDTH(WIDTH), .CH_W(CH_W)) eng_bus ();

    fir_channel_scheduler #(
        .WIDTH   (WIDTH),
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ch_audio_in (ch_audio_in),
        .ch_valid_in (ch_valid_in),
        .clr_err_in  (clr_err_in),
        .bus         (eng_bus),
        .busy_out    (busy_out),
        .overrun_out (overrun_out),
        .timeout_out (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    // Step negedges until eng_valid_out is seen or the budget runs out.
    task automatic wait_valid(input int budget, output bit found, output int n);
        found = 1'b0;
        n     = 0;
        while (!found && n < budget) begin
            @(negedge clk_in);
            n++;
            if (eng_bus.eng_valid_out) found = 1'b1;
        end
    endtask

    // One-cycle engine done pulse; returns on the negedge where the result is visible.
    task automatic engine_reply(input logic [WIDTH-1:0] d);
        eng_bus.eng_audio_in = d;
        eng_bus.eng_ready_in = 1'b1;
        @(negedge clk_in);
        eng_bus.eng_ready_in = 1'b0;
        eng_bus.eng_audio_in = '0;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        ch_valid_in = '0;
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        total++;
        if ({eng_bus.eng_audio_out, eng_bus.eng_ch_out, eng_bus.eng_valid_out, eng_bus.result_out,
             eng_bus.result_ch_out, eng_bus.result_valid_out, busy_out, overrun_out, timeout_out} !== 28'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b ovr=%b to=%b eng=%h res=%h want all zero",
                     busy_out, overrun_out, timeout_out, eng_bus.eng_audio_out, eng_bus.result_out);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_single();
        ch_audio_in[2*WIDTH +: WIDTH] = 8'h10;
        ch_valid_in = 4'b0100;
        @(negedge clk_in);
        ch_valid_in = '0;
        total++;
        if (eng_bus.eng_valid_out !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", eng_bus.eng_valid_out); end
        @(negedge clk_in);
        total++;
        if ({eng_bus.eng_valid_out, eng_bus.eng_ch_out, eng_bus.eng_audio_out} !== {1'b1, 2'd2, 8'h10}) begin
            bad++;
            $display("FAIL single_issue: got v=%b ch=%0d d=%h want v=1 ch=2 d=10",
                     eng_bus.eng_valid_out, eng_bus.eng_ch_out, eng_bus.eng_audio_out);
        end
        @(negedge clk_in);
        total++;
        if (eng_bus.eng_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            bad++; $display("FAIL single_pulse_width: got v=%b busy=%b want v=0 busy=1", eng_bus.eng_valid_out, busy_out);
        end
        repeat (32) @(negedge clk_in);
        total++;
        if ({eng_bus.result_valid_out, eng_bus.eng_ch_out, eng_bus.eng_audio_out} !== {1'b0, 2'd2, 8'h10}) begin
            bad++;
            $display("FAIL single_hold: got rv=%b ch=%0d d=%h want rv=0 ch=2 d=10",
                     eng_bus.result_valid_out, eng_bus.eng_ch_out, eng_bus.eng_audio_out);
        end
        engine_reply(8'h35);
        total++;
        if ({eng_bus.result_valid_out, eng_bus.result_ch_out, eng_bus.result_out} !== {1'b1, 2'd2, 8'h35}) begin
            bad++;
            $display("FAIL single_result: got rv=%b ch=%0d d=%h want rv=1 ch=2 d=35",
                     eng_bus.result_valid_out, eng_bus.result_ch_out, eng_bus.result_out);
        end
        @(negedge clk_in);
        total++;
        if (eng_bus.result_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            bad++; $display("FAIL single_return_idle: got rv=%b busy=%b want 0 0", eng_bus.result_valid_out, busy_out);
        end
    endtask

    task automatic test_round_robin();
        bit found;
        int n;
        pulse_reset();
        for (int c = 0; c < 4; c++) ch_audio_in[c*WIDTH +: WIDTH] = 8'(c + 1);
        ch_valid_in = 4'b1111;
        @(negedge clk_in);
        ch_valid_in = '0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(8, found, n);
            total++;
            if (!found || eng_bus.eng_ch_out !== 2'(i) || eng_bus.eng_audio_out !== 8'(i + 1)) begin
                bad++;
                $display("FAIL rr_issue_%0d: got found=%b ch=%0d d=%h want ch=%0d d=%h",
                         i, found, eng_bus.eng_ch_out, eng_bus.eng_audio_out, i, i + 1);
            end
            if (i > 0) begin
                total++;
                if (n !== 2) begin bad++; $display("FAIL rr_gap_%0d: got %0d cycles want 2", i, n); end
            end
            @(negedge clk_in);
            engine_reply(8'h40 + 8'(i));
            total++;
            if ({eng_bus.result_valid_out, eng_bus.result_ch_out, eng_bus.result_out} !== {1'b1, 2'(i), 8'h40 + 8'(i)}) begin
                bad++;
                $display("FAIL rr_result_%0d: got rv=%b ch=%0d d=%h", i,
                         eng_bus.result_valid_out, eng_bus.result_ch_out, eng_bus.result_out);
            end
        end
        @(negedge clk_in);
        total++;
        if (busy_out !== 1'b0 || overrun_out !== 4'b0000) begin
            bad++; $display("FAIL rr_done: got busy=%b ovr=%b want 0 0000", busy_out, overrun_out);
        end
    endtask

    task automatic test_overrun();
        bit found;
        int n;
        ch_audio_in[0 +: WIDTH] = 8'h05;
        ch_valid_in = 4'b0001;
        @(negedge clk_in);
        ch_valid_in = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        ch_audio_in[WIDTH +: WIDTH] = 8'h11;
        ch_valid_in = 4'b0010;
        @(negedge clk_in);
        ch_audio_in[WIDTH +: WIDTH] = 8'h22;
        @(negedge clk_in);
        ch_valid_in = '0;
        total++;
        if (overrun_out !== 4'b0010) begin bad++; $display("FAIL ovr_flag: got %b want 0010", overrun_out); end
        engine_reply(8'h50);
        wait_valid(6, found, n);
        total++;
        if (!found || eng_bus.eng_ch_out !== 2'd1 || eng_bus.eng_audio_out !== 8'h22) begin
            bad++;
            $display("FAIL ovr_issue: got found=%b ch=%0d d=%h want ch=1 d=22", found, eng_bus.eng_ch_out, eng_bus.eng_audio_out);
        end
        @(negedge clk_in);
        engine_reply(8'h51);
        total++;
        if (overrun_out !== 4'b0010) begin bad++; $display("FAIL ovr_sticky: got %b want 0010", overrun_out); end
        clr_err_in = 1'b1;
        @(negedge clk_in);
        clr_err_in = 1'b0;
        total++;
        if (overrun_out !== 4'b0000) begin bad++; $display("FAIL ovr_clear: got %b want 0000", overrun_out); end
        @(negedge clk_in);
    endtask

    task automatic test_same_cycle();
        bit found;
        int n;
        ch_audio_in[0 +: WIDTH] = 8'h0A;
        ch_valid_in = 4'b0001;
        @(negedge clk_in);
        ch_valid_in = '0;
        wait_valid(6, found, n);
        total++;
        if (!found || eng_bus.eng_ch_out !== 2'd0 || eng_bus.eng_audio_out !== 8'h0A) begin
            bad++; $display("FAIL same_first: got found=%b ch=%0d d=%h want ch=0 d=0a", found, eng_bus.eng_ch_out, eng_bus.eng_audio_out);
        end
        ch_audio_in[0 +: WIDTH] = 8'h0B;
        ch_valid_in = 4'b0001;
        @(negedge clk_in);
        ch_valid_in = '0;
        engine_reply(8'h60);
        wait_valid(6, found, n);
        total++;
        if (!found || eng_bus.eng_ch_out !== 2'd0 || eng_bus.eng_audio_out !== 8'h0B || overrun_out !== 4'b0000) begin
            bad++;
            $display("FAIL same_second: got found=%b ch=%0d d=%h ovr=%b want ch=0 d=0b ovr=0000",
                     found, eng_bus.eng_ch_out, eng_bus.eng_audio_out, overrun_out);
        end
        @(negedge clk_in);
        engine_reply(8'h61);
        @(negedge clk_in);
    endtask

    task automatic test_timeout();
        bit found;
        int n;
        bit saw_result;
        ch_audio_in[1*WIDTH +: WIDTH] = 8'h21;
        ch_audio_in[3*WIDTH +: WIDTH] = 8'h33;
        ch_valid_in = 4'b1010;
        @(negedge clk_in);
        ch_valid_in = '0;
        wait_valid(6, found, n);
        total++;
        if (!found || eng_bus.eng_ch_out !== 2'd1) begin
            bad++; $display("FAIL to_first: got found=%b ch=%0d want ch=1", found, eng_bus.eng_ch_out);
        end
        saw_result = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(negedge clk_in);
            if (eng_bus.result_valid_out) saw_result = 1'b1;
        end
        total++;
        if (timeout_out !== 1'b0 || busy_out !== 1'b1) begin
            bad++; $display("FAIL to_early: got to=%b busy=%b want 0 1", timeout_out, busy_out);
        end
        @(negedge clk_in);
        if (eng_bus.result_valid_out) saw_result = 1'b1;
        total++;
        if (timeout_out !== 1'b1 || busy_out !== 1'b0 || saw_result !== 1'b0) begin
            bad++; $display("FAIL to_fire: got to=%b busy=%b res=%b want 1 0 0", timeout_out, busy_out, saw_result);
        end
        wait_valid(4, found, n);
        total++;
        if (!found || n !== 1 || eng_bus.eng_ch_out !== 2'd3 || eng_bus.eng_audio_out !== 8'h33) begin
            bad++;
            $display("FAIL to_next: got found=%b n=%0d ch=%0d d=%h want n=1 ch=3 d=33",
                     found, n, eng_bus.eng_ch_out, eng_bus.eng_audio_out);
        end
        @(negedge clk_in);
        engine_reply(8'h70);
        clr_err_in = 1'b1;
        @(negedge clk_in);
        clr_err_in = 1'b0;
        total++;
        if (timeout_out !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout_out); end
    endtask

    task automatic test_reset_mid_wait();
        bit found;
        int n;
        ch_audio_in[2*WIDTH +: WIDTH] = 8'h44;
        ch_valid_in = 4'b0100;
        @(negedge clk_in);
        ch_valid_in = '0;
        wait_valid(6, found, n);
        @(negedge clk_in);
        @(negedge clk_in);
        pulse_reset();
        total++;
        if ({eng_bus.eng_audio_out, eng_bus.eng_ch_out, eng_bus.eng_valid_out, eng_bus.result_out,
             eng_bus.result_ch_out, eng_bus.result_valid_out, busy_out, overrun_out, timeout_out} !== 28'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got busy=%b eng=%h ch=%0d want all zero",
                     busy_out, eng_bus.eng_audio_out, eng_bus.eng_ch_out);
        end
        engine_reply(8'h7F);
        total++;
        if (eng_bus.result_valid_out !== 1'b0 || eng_bus.result_out !== 8'h00) begin
            bad++; $display("FAIL midrst_late_ready: got rv=%b d=%h want 0 00", eng_bus.result_valid_out, eng_bus.result_out);
        end
        wait_valid(5, found, n);
        total++;
        if (found !== 1'b0) begin bad++; $display("FAIL midrst_no_issue: got valid after %0d cycles want none", n); end
        ch_audio_in[0 +: WIDTH] = 8'h0C;
        ch_audio_in[1*WIDTH +: WIDTH] = 8'h1C;
        ch_valid_in = 4'b0011;
        @(negedge clk_in);
        ch_valid_in = '0;
        wait_valid(6, found, n);
        total++;
        if (!found || eng_bus.eng_ch_out !== 2'd0 || eng_bus.eng_audio_out !== 8'h0C) begin
            bad++; $display("FAIL midrst_restart: got found=%b ch=%0d d=%h want ch=0 d=0c", found, eng_bus.eng_ch_out, eng_bus.eng_audio_out);
        end
    endtask

    initial begin
        rst_in               = 1'b0;
        ch_audio_in          = '0;
        ch_valid_in          = '0;
        clr_err_in           = 1'b0;
        eng_bus.eng_audio_in = '0;
        eng_bus.eng_ready_in = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_same_cycle();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Time-multiplexes one shared FIR engine across `NUM_CH` audio channels. Each channel presents samples at its own valid strobes. The scheduler latches one pending sample per channel, grants the engine round-robin, and issues one sample at a time with a start pulse. It waits for the engine's done pulse, or a timeout, and returns the filtered result tagged with its channel. It sits between the per-channel sample sources (ADC/decimator outputs) and the FIR MAC engine, which keeps per-channel delay lines selected by `eng_ch_out`.

## Interface
- `WIDTH`, 8: sample width, signed two's complement, in and out.
- `NUM_CH`, 4: number of requesting channels, 2..16.
- `TIMEOUT`, 64: maximum cycles in WAIT before the request is aborted; must exceed engine worst-case latency (taps + 2).
- `clk_in` input 1: single clock; all logic on its rising edge.
- `rst_in` input 1: reset, synchronous, active-low.
- `ch_audio_in` input `NUM_CH*WIDTH`: channel c sample in bits `[c*WIDTH +: WIDTH]`.
- `ch_valid_in` input `NUM_CH`: one-cycle strobe per channel; sample valid that cycle.
- `clr_err_in` input 1: clears the sticky `overrun_out` and `timeout_out`.
- `eng_audio_out` output `WIDTH`: sample issued to the engine.
- `eng_ch_out` output `$clog2(NUM_CH)`: channel of the issued sample, held from ISSUE through WAIT.
- `eng_valid_out` output 1: one-cycle start pulse to the engine.
- `eng_audio_in` input `WIDTH`: engine result.
- `eng_ready_in` input 1: engine done pulse; `eng_audio_in` is valid that cycle.
- `result_out` output `WIDTH`: filtered sample.
- `result_ch_out` output `$clog2(NUM_CH)`: channel of `result_out`.
- `result_valid_out` output 1: one-cycle pulse.
- `busy_out` output 1: high whenever state ≠ IDLE.
- `overrun_out` output `NUM_CH`: sticky per channel; a new sample arrived while the previous one was still pending.
- `timeout_out` output 1: sticky; the engine failed to respond within `TIMEOUT` cycles.

## Operation
- **Pending bank.** One `WIDTH`-bit sample register plus a pending bit per channel.
  - `ch_valid_in[c]` sets pending[c] and loads the sample.
  - If pending[c] is already set: the new sample overwrites the old one and overrun[c] is set.
- **State machine:** IDLE, ISSUE, WAIT, EMIT.
  - **IDLE:** if any pending bit is set, the grant goes to the first pending channel searching upward from `last_grant+1`, modulo `NUM_CH`. Register the grant, copy its sample to `eng_audio_out`, and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE:** `eng_valid_out=1` for exactly this cycle and pending[grant] is cleared. `last_grant` takes the value of grant, the timer is set to 0, and the FSM goes to WAIT.
    - If `ch_valid_in[grant]` is high in this same cycle, the new sample is latched with pending set and no overrun is flagged.
  - **WAIT:** `eng_audio_out` and `eng_ch_out` are held stable.
    - On `eng_ready_in`: capture `eng_audio_in` into `result_out`, set `result_ch_out` to grant, go to EMIT.
    - Otherwise the timer increments. At timer = `TIMEOUT-1` with no ready: set `timeout_out`, go to IDLE, emit no result.
    - If ready and timeout occur in the same cycle, ready wins.
  - **EMIT:** `result_valid_out=1` for one cycle, then go to IDLE.
- `eng_ready_in` outside WAIT is ignored.
- `clr_err_in` clears both sticky flags. An overrun or timeout event in the same cycle wins, so the flag stays set.
- Results are passed through unmodified. There is no width change or saturation in this block.

## Timing
- **Reset** (`rst_in=0` at an edge): state IDLE, all pending bits 0, `last_grant=NUM_CH-1` (so channel 0 wins first). Every output resets to 0: `eng_audio_out`, `eng_ch_out`, `eng_valid_out`, `result_out`, `result_ch_out`, `result_valid_out`, `busy_out`, `overrun_out`, `timeout_out`.
- **Reset mid-operation** overrides every state. Any in-flight engine result is dropped. The engine sees no further `eng_valid_out` until new samples arrive.
- **Issue latency:** `ch_valid_in` high in cycle k with the FSM idle gives `eng_valid_out` high in cycle k+2 (pending set at k+1, ISSUE at k+2).
- **Return latency:** `eng_ready_in` in cycle m gives `result_valid_out` in cycle m+1. IDLE is at m+2, and the next `eng_valid_out` can be no earlier than m+3.
- **Service order** with all channels continuously pending is 0, 1, …, `NUM_CH-1`, 0, … No channel waits more than `NUM_CH-1` services.
- **Outputs:** all are registered; no combinational path from any input to any output.

## Structure
- **Package `fir_sched_pkg`:**
  - the `sched_state_t` enum (IDLE, ISSUE, WAIT, EMIT);
  - the `CH_W = $clog2(NUM_CH)` helper function;
  - the default `TIMEOUT` constant.
- **Sub-module `rr_arbiter`:** purely combinational. Inputs are the pending vector and `last_grant`; outputs are `grant_idx` and `grant_any`. It is reusable for other shared resources.
- **Top level:** the pending bank, FSM, timer and sticky flags.

## Test plan
- **Single request:** reset, then `ch_valid_in[2]` with sample 0x10 at cycle 0. Expect `eng_valid_out` at cycle 2 with `eng_ch_out=2`, `eng_audio_out=0x10`. The engine responds with 0x35 after 33 cycles; expect `result_valid_out` the next cycle with `result_out=0x35`, `result_ch_out=2`.
- **Round-robin:** all 4 channels strobe in the same cycle with samples 0x01..0x04. Expect issue order 0, 1, 2, 3, then `busy_out` low.
- **Overrun:** channel 1 strobes 0x11 then 0x22 while channel 0 is in WAIT. Expect channel 1 issued with 0x22 and `overrun_out=4'b0010` until `clr_err_in`.
- **Same-cycle re-request:** `ch_valid_in[0]` asserted in the ISSUE cycle of channel 0. Expect a second issue for channel 0 and `overrun_out[0]=0`.
- **Timeout:** the engine never asserts ready. Expect `timeout_out=1` at `TIMEOUT` cycles after ISSUE, no `result_valid_out`, and the next pending channel issued.
- **Reset mid-WAIT:** pull `rst_in` low for one cycle. Expect all outputs 0, and a late `eng_ready_in` ignored with no result.
